wired_fetch_queue: RTL

//  Decoupling FIFO between the PC generator and the I-cache request stage.
//  - Accepts one fetch packet per cycle from the PC generator: PC, 2-slot mask and 2x bpu_predict_t.
//  - Holds packets until the I-cache stage accepts them; absorbs I-cache stalls without throttling prediction.
//  - Flushes all contents on a redirect from the back end.

---
 rtl/wired_fetch_queue_pkg.sv | 25 ++
 rtl/wired_fetch_queue_ram.sv | 27 ++
 rtl/wired_fetch_queue.sv | 102 ++++++++++
 3 files changed

// File: rtl/wired_fetch_queue_pkg.sv
// Shared types for the fetch decoupling queue.
// Holds the fetch packet bundle and its branch-prediction metadata.
package wired_fetch_queue_pkg;

  typedef struct packed {
    logic        taken;
    logic [1:0]  ctr;
    logic [31:0] target;
  } bpu_predict_t;

  typedef bpu_predict_t [1:0] pred_pair_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  mask;
    pred_pair_t  predict;
  } fetch_pkt_t;

  localparam int FQ_DEPTH = 4;

  function automatic logic pkt_live(logic [1:0] m);
    return |m;
  endfunction

endpackage

// File: rtl/wired_fetch_queue_ram.sv
// Packet storage for the fetch queue.
// One write port, one asynchronous read port.
module wired_fetch_queue_ram
  import wired_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  fetch_pkt_t       wdata,
  input  logic [PTR_W-1:0] raddr,
  output fetch_pkt_t       rdata
);

  fetch_pkt_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wired_fetch_queue.sv
// Fetch queue between PC generator and I-cache request stage.
// Define WIRED_FETCH_QUEUE_BYPASS_EN for the zero-latency empty bypass.
module wired_fetch_queue
  import wired_fetch_queue_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             f_valid_i,
  output logic             f_ready_o,
  input  logic [31:0]      f_pc_i,
  input  logic [1:0]       f_mask_i,
  input  pred_pair_t       f_predict_i,
  output logic             q_valid_o,
  input  logic             q_ready_i,
  output logic [31:0]      q_pc_o,
  output logic [1:0]       q_mask_o,
  output pred_pair_t       q_predict_o,
  output logic [PTR_W:0]   q_count_o
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             accept;
  logic             bypass;
  logic             push;
  logic             pop;
  fetch_pkt_t       wr_pkt;
  fetch_pkt_t       rd_pkt;
  fetch_pkt_t       head;

  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign wr_pkt = '{pc: f_pc_i, mask: f_mask_i, predict: f_predict_i};

  // Ready comes from registered count only: no slot reuse on a full dequeue.
  assign f_ready_o = !full;
  assign accept    = f_valid_i & f_ready_o & !flush_i;

`ifdef WIRED_FETCH_QUEUE_BYPASS_EN
  assign bypass = accept & empty & q_ready_i & pkt_live(f_mask_i);
  assign head   = bypass ? wr_pkt : (empty ? '0 : rd_pkt);
`else
  assign bypass = 1'b0;
  assign head   = empty ? '0 : rd_pkt;
`endif

  assign push      = accept & pkt_live(f_mask_i) & !bypass;
  assign pop       = !empty & q_ready_i & !flush_i;
  assign q_valid_o = (!empty | bypass) & !flush_i;

  assign q_pc_o      = head.pc;
  assign q_mask_o    = head.mask;
  assign q_predict_o = head.predict;
  assign q_count_o   = count;

  wired_fetch_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_pkt),
    .raddr (rd_ptr),
    .rdata (rd_pkt)
  );

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_ovf: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_udf: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
`endif

endmodule
